score_buffer: RTL and testbench

SCORE_BUFFER -- requirements
Module: score_buffer

---
 rtl/score_buffer.sv | 195 +++++++++++++++++++
 tb/tb_score_buffer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_buffer.sv
// score_buffer
//   Collects one frame of signed scores from a producer, hands the frame to an
//   external argmax engine, and holds the winning index until a consumer
//   accepts it.
//
// Parameters
//   DEPTH   score entries stored per frame (<= 16, limited by am_max_index)
//   DATA_W  signed score width
//
// Ports
//   clk, resetn                    clock, asynchronous active-low reset
//   size                           requested frame length, sampled on the first
//                                  accepted element of each frame
//   in_valid / in_ready / in_data  producer score stream
//   am_start                       one-cycle launch pulse to the argmax engine
//   am_size                        latched effective frame length
//   am_addr / am_data              combinational read port for the engine
//   am_done / am_max_index         engine completion level and result
//   res_valid / res_ready          result handshake to the consumer
//   res_index / res_frame          winning index and its frame sequence number

module score_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [15:0]              size,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     am_start,
  output logic [15:0]              am_size,
  input  logic [15:0]              am_addr,
  output logic signed [DATA_W-1:0] am_data,
  input  logic                     am_done,
  input  logic [3:0]               am_max_index,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [3:0]               res_index,
  output logic [7:0]               res_frame
);

  // NW holds counts 0..DEPTH inclusive; AW addresses 0..DEPTH-1.
  localparam int unsigned NW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_FILL,
    S_LAUNCH,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic [NW-1:0]            r_wr_ptr;
  logic [NW-1:0]            r_n_eff;
  logic [NW-1:0]            w_size_eff;
  logic [NW-1:0]            w_n_eff_cur;
  logic                     w_push;
  logic                     w_capture;
  logic                     w_release;

  logic [3:0]               r_res_index;
  logic [7:0]               r_res_frame;

  logic signed [DATA_W-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Effective frame length
  // ---------------------------------------------------------------------------
  always_comb begin
    w_size_eff = NW'(DEPTH);
    if ((size != '0) && (size <= 16'(DEPTH))) begin
      w_size_eff = NW'(size);
    end
  end

  // The first transfer of a frame must use the freshly sampled length so that
  // a single-entry frame can finish on that same transfer.
  assign w_n_eff_cur = (r_wr_ptr == '0) ? w_size_eff : r_n_eff;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    am_start    = 1'b0;
    res_valid   = 1'b0;
    w_push      = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;

    unique case (r_state)
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_push = 1'b1;
          if (r_wr_ptr == (w_n_eff_cur - NW'(1))) begin
            w_state_nxt = S_LAUNCH;
          end
        end
      end

      // am_done is deliberately not looked at here: a level left over from
      // the previous frame must not be mistaken for this frame's result.
      S_LAUNCH: begin
        am_start    = 1'b1;
        w_state_nxt = S_WAIT;
      end

      S_WAIT: begin
        if (am_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESULT;
        end
      end

      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_release   = 1'b1;
          w_state_nxt = S_FILL;
        end
      end

      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame bookkeeping and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_n_eff     <= NW'(DEPTH);
      r_res_index <= '0;
      r_res_frame <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + NW'(1);
        if (r_wr_ptr == '0) begin
          r_n_eff <= w_size_eff;
        end
      end
      if (w_capture) begin
        r_res_index <= am_max_index;
      end
      if (w_release) begin
        r_wr_ptr    <= '0;
        r_res_frame <= r_res_frame + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Score storage (no reset; contents are only meaningful once written)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= in_data;
    end
  end

  // Out-of-frame addresses read as the most negative score so they can never
  // win the argmax.
  always_comb begin
    am_data = {1'b1, {(DATA_W-1){1'b0}}};
    if (am_addr < 16'(r_n_eff)) begin
      am_data = r_mem[am_addr[AW-1:0]];
    end
  end

  assign am_size   = 16'(r_n_eff);
  assign res_index = r_res_index;
  assign res_frame = r_res_frame;

endmodule

// File: tb/tb_score_buffer.sv
// tb_score_buffer
//   Directed bench for score_buffer. The bench plays producer, argmax engine
//   and consumer; every expected value is written by hand from the scores fed.

module tb_score_buffer;

  logic               clk;
  logic               resetn;
  logic [15:0]        size;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data;
  logic               am_start;
  logic [15:0]        am_size;
  logic [15:0]        am_addr;
  logic signed [31:0] am_data;
  logic               am_done;
  logic [3:0]         am_max_index;
  logic               res_valid;
  logic               res_ready;
  logic [3:0]         res_index;
  logic [7:0]         res_frame;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [31:0] sc [16];
  logic [7:0]  exp_frame;

  localparam logic [31:0] MOST_NEG = 32'h8000_0000;

  score_buffer #(
    .DEPTH  (16),
    .DATA_W (32)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .size         (size),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .am_start     (am_start),
    .am_size      (am_size),
    .am_addr      (am_addr),
    .am_data      (am_data),
    .am_done      (am_done),
    .am_max_index (am_max_index),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_index    (res_index),
    .res_frame    (res_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams sc[0..n-1]; size is sz_first on the first element, sz_rest after.
  task automatic push(input int n, input logic [15:0] sz_first, input logic [15:0] sz_rest);
    for (int i = 0; i < n; i++) begin
      size     = (i == 0) ? sz_first : sz_rest;
      in_valid = 1'b1;
      in_data  = sc[i];
      chk("fill_in_ready", {31'd0, in_ready}, 32'd1);
      chk("fill_am_start", {31'd0, am_start}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Called right after the edge that took the last element.
  task automatic launch(input logic [15:0] exp_size);
    chk("launch_am_start", {31'd0, am_start}, 32'd1);
    chk("launch_in_ready", {31'd0, in_ready}, 32'd0);
    chk("launch_am_size", {16'd0, am_size}, {16'd0, exp_size});
    tick();
    chk("wait_am_start", {31'd0, am_start}, 32'd0);
    chk("wait_res_valid", {31'd0, res_valid}, 32'd0);
  endtask

  task automatic finish_result(input logic [3:0] idx, input logic [15:0] exp_size);
    am_done      = 1'b1;
    am_max_index = idx;
    tick();
    am_done = 1'b0;
    chk("res_valid", {31'd0, res_valid}, 32'd1);
    chk("res_index", {28'd0, res_index}, {28'd0, idx});
    chk("res_frame", {24'd0, res_frame}, {24'd0, exp_frame});
    chk("res_am_size", {16'd0, am_size}, {16'd0, exp_size});
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_frame = exp_frame + 8'd1;
    chk("accept_res_valid", {31'd0, res_valid}, 32'd0);
    chk("accept_in_ready", {31'd0, in_ready}, 32'd1);
    chk("accept_res_frame", {24'd0, res_frame}, {24'd0, exp_frame});
  endtask

  task automatic rd(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    am_addr = addr;
    #1;
    chk(tag, am_data, exp);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    exp_frame    = 8'd0;
    resetn       = 1'b1;
    size         = 16'd0;
    in_valid     = 1'b0;
    in_data      = '0;
    am_addr      = 16'd0;
    am_done      = 1'b0;
    am_max_index = 4'd0;
    res_ready    = 1'b0;

    // Reset values.
    #3 resetn = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_am_start", {31'd0, am_start}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_index", {28'd0, res_index}, 32'd0);
    chk("rst_res_frame", {24'd0, res_frame}, 32'd0);
    chk("rst_am_size", {16'd0, am_size}, 32'd16);
    #19 resetn = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // size=10; maximum 100 at index 3.
    sc[0] = 5;   sc[1] = -3; sc[2] = 7;  sc[3] = 100; sc[4] = 2;
    sc[5] = 0;   sc[6] = -50; sc[7] = 99; sc[8] = 1;  sc[9] = 4;
    push(10, 16'd10, 16'd10);
    rd("rd10_addr0", 16'd0, 32'd5);
    rd("rd10_addr3", 16'd3, 32'd100);
    rd("rd10_addr9", 16'd9, 32'd4);
    rd("rd10_addr10", 16'd10, MOST_NEG);
    rd("rd10_addr12", 16'd12, MOST_NEG);
    rd("rd10_addr1", 16'd1, 32'hFFFF_FFFD);
    launch(16'd10);
    finish_result(4'd3, 16'd10);
    accept();

    // size=0 means full depth; only entry 15 is non-negative.
    for (int i = 0; i < 16; i++) sc[i] = 32'hFFFF_FFFF;
    sc[15] = 32'd0;
    push(16, 16'd0, 16'd0);
    rd("rd16_addr0", 16'd0, 32'hFFFF_FFFF);
    rd("rd16_addr15", 16'd15, 32'd0);
    rd("rd16_addr16", 16'd16, MOST_NEG);
    launch(16'd16);
    finish_result(4'd15, 16'd16);
    accept();

    // size=4 sampled on the first element only; result held under backpressure.
    sc[0] = 1; sc[1] = 2; sc[2] = 3; sc[3] = -4;
    push(4, 16'd4, 16'd2);
    launch(16'd4);
    finish_result(4'd2, 16'd4);
    in_valid = 1'b1;
    in_data  = 999;
    size     = 16'd9;
    for (int c = 0; c < 20; c++) begin
      am_done      = c[0];
      am_max_index = 4'd7;
      tick();
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_res_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_res_index", {28'd0, res_index}, 32'd2);
    end
    in_valid = 1'b0;
    am_done  = 1'b0;
    chk("hold_res_frame", {24'd0, res_frame}, {24'd0, exp_frame});
    chk("hold_am_size", {16'd0, am_size}, 32'd4);
    rd("hold_addr0", 16'd0, 32'd1);
    rd("hold_addr2", 16'd2, 32'd3);
    rd("hold_addr3", 16'd3, 32'hFFFF_FFFC);
    rd("hold_addr4", 16'd4, MOST_NEG);
    accept();

    // Single-entry frame with am_done still high from the previous frame.
    sc[0] = 7;
    am_done      = 1'b1;
    am_max_index = 4'd9;
    push(1, 16'd1, 16'd1);
    rd("rd1_addr0", 16'd0, 32'd7);
    rd("rd1_addr1", 16'd1, MOST_NEG);
    launch(16'd1);
    am_done = 1'b0;
    tick();
    chk("stale_res_valid_a", {31'd0, res_valid}, 32'd0);
    tick();
    chk("stale_res_valid_b", {31'd0, res_valid}, 32'd0);
    finish_result(4'd0, 16'd1);
    accept();

    // Reset during WAIT of a size=8 frame.
    for (int i = 0; i < 8; i++) sc[i] = i;
    push(8, 16'd8, 16'd8);
    launch(16'd8);
    #2 resetn = 1'b0;
    #1;
    chk("async_res_frame", {24'd0, res_frame}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_am_size", {16'd0, am_size}, 32'd16);
    chk("async_res_valid", {31'd0, res_valid}, 32'd0);
    #2 resetn = 1'b1;
    exp_frame = 8'd0;
    am_done   = 1'b1;
    tick();
    am_done = 1'b0;
    chk("rel_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Partial frame discarded by a reset during FILL.
    push(2, 16'd5, 16'd5);
    #2 resetn = 1'b0;
    #3 resetn = 1'b1;
    tick();
    chk("partial_in_ready", {31'd0, in_ready}, 32'd1);

    // Fresh size=3 frame after the resets; maximum -2 at index 1.
    sc[0] = -10; sc[1] = -2; sc[2] = -7;
    push(3, 16'd3, 16'd3);
    rd("rd3_addr0", 16'd0, 32'hFFFF_FFF6);
    rd("rd3_addr3", 16'd3, MOST_NEG);
    launch(16'd3);
    finish_result(4'd1, 16'd3);
    accept();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
